// File: rtl/snake_pkg.sv
// Shared definitions for the snake game core: direction encodings,
// FSM states and default colours.
package snake_pkg;

  // Direction one-hot layout is {up, down, left, right}
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_ERASE,
    ST_DRAW,
    ST_COMMIT,
    ST_DEAD
  } state_t;

  // Opposite heading: swaps up/down and left/right
  function automatic logic [3:0] dir_reverse(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Body segment store: one write port, one synchronous read port, no reset.
// Each word holds a packed {x, y} coordinate.
module snake_body_ram #(
  parameter  int DEPTH = 1024,
  parameter  int W     = 15,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write on request; read data appears the cycle after the address
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: circular body buffer, one-cell step per tick, wall and
// self collision, and a valid/ready plot stream (erase tail, draw head).
// Optional macro SNAKE_WRAP_EN: grid edges wrap instead of killing the snake.
module snake_engine
  import snake_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int GRID_X    = 160,
  parameter int GRID_Y    = 120,
  parameter int MAX_LEN   = 1024,
  parameter int START_X   = 80,
  parameter int START_Y   = 60,
  parameter int START_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [3:0]                dir_in,
  input  logic                      grow,
  input  logic [2:0]                colour_snake,
  input  logic [2:0]                colour_bg,
  output logic [X_W-1:0]            plot_x,
  output logic [Y_W-1:0]            plot_y,
  output logic [2:0]                plot_colour,
  output logic                      plot_valid,
  input  logic                      plot_ready,
  output logic [X_W-1:0]            head_x,
  output logic [Y_W-1:0]            head_y,
  output logic [$clog2(MAX_LEN):0]  length,
  output logic                      busy,
  output logic                      dead
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(GRID_X - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(GRID_Y - 1);
  localparam logic [X_W-1:0]   X_TAIL0   = X_W'(START_X - START_LEN + 1);
  localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(START_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_LEN);

  state_t             state, state_nxt;
  logic               started;
  logic [3:0]         dir_cur, dir_req, dir_ref;
  logic [PTR_W-1:0]   head_ptr, tail_ptr, scan_ptr;
  logic [LEN_W-1:0]   init_cnt, scan_idx;
  logic               pending, grow_latch, step_grow;
  logic [X_W-1:0]     next_x, tail_x, calc_x, init_x;
  logic [Y_W-1:0]     next_y, tail_y, calc_y;
  logic               calc_wall, scan_hit, accept;
  logic               ram_we;
  logic [PTR_W-1:0]   ram_waddr, ram_raddr;
  logic [X_W+Y_W-1:0] ram_wdata, ram_rdata;

  snake_body_ram #(
    .DEPTH (MAX_LEN),
    .W     (X_W + Y_W)
  ) u_body (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // started holds plot_valid low in the first cycle after reset
  assign plot_valid = started && (state == ST_INIT || state == ST_ERASE || state == ST_DRAW);
  assign accept     = plot_valid && plot_ready;
  assign busy       = (state != ST_IDLE) && (state != ST_DEAD);
  assign dead       = (state == ST_DEAD);
  assign init_x     = X_TAIL0 + X_W'(init_cnt);
  assign dir_ref    = (state == ST_CALC) ? dir_req : dir_cur;
  assign scan_hit   = ((scan_idx != '0) || step_grow) && (ram_rdata == {next_x, next_y});

  // Candidate next head cell and edge handling for the latched direction
  always_comb begin
    calc_x    = head_x;
    calc_y    = head_y;
    calc_wall = 1'b0;
    case (dir_req)
      DIR_RIGHT: begin
        if (head_x == X_LAST) begin
`ifdef SNAKE_WRAP_EN
          calc_x = '0;
`else
          calc_wall = 1'b1;
`endif
        end else calc_x = head_x + 1'b1;
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
          calc_x = X_LAST;
`else
          calc_wall = 1'b1;
`endif
        end else calc_x = head_x - 1'b1;
      end
      DIR_DOWN: begin
        if (head_y == Y_LAST) begin
`ifdef SNAKE_WRAP_EN
          calc_y = '0;
`else
          calc_wall = 1'b1;
`endif
        end else calc_y = head_y + 1'b1;
      end
      DIR_UP: begin
        if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
          calc_y = Y_LAST;
`else
          calc_wall = 1'b1;
`endif
        end else calc_y = head_y - 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic, plot mux and body buffer port control
  always_comb begin
    state_nxt   = state;
    plot_x      = '0;
    plot_y      = '0;
    plot_colour = '0;
    ram_we      = 1'b0;
    ram_waddr   = head_ptr;
    ram_wdata   = {next_x, next_y};
    ram_raddr   = scan_ptr;
    case (state)
      ST_INIT: begin
        plot_x      = init_x;
        plot_y      = Y_START;
        plot_colour = colour_snake;
        ram_we      = accept;
        ram_wdata   = {init_x, Y_START};
        if (accept && init_cnt == INIT_LAST) state_nxt = ST_IDLE;
      end
      ST_IDLE: if (tick || pending) state_nxt = ST_CALC;
      ST_CALC: begin
        ram_raddr = tail_ptr;
        state_nxt = calc_wall ? ST_DEAD : ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_hit) state_nxt = ST_DEAD;
        else if (scan_idx == length - 1'b1) state_nxt = step_grow ? ST_DRAW : ST_ERASE;
      end
      ST_ERASE: begin
        plot_x      = tail_x;
        plot_y      = tail_y;
        plot_colour = colour_bg;
        if (accept) state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        plot_x      = next_x;
        plot_y      = next_y;
        plot_colour = colour_snake;
        ram_we      = accept;
        if (accept) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_DEAD:   state_nxt = ST_DEAD;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // State, pointers, direction/tick/grow latches and the committed head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      started    <= 1'b0;
      dir_cur    <= DIR_RIGHT;
      dir_req    <= DIR_RIGHT;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      scan_ptr   <= '0;
      init_cnt   <= '0;
      scan_idx   <= '0;
      pending    <= 1'b0;
      grow_latch <= 1'b0;
      step_grow  <= 1'b0;
      next_x     <= '0;
      next_y     <= '0;
      tail_x     <= '0;
      tail_y     <= '0;
      head_x     <= X_START;
      head_y     <= Y_START;
      length     <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (state != ST_DEAD && $onehot(dir_in) && dir_in != dir_reverse(dir_ref))
        dir_req <= dir_in;
      if (state == ST_IDLE) pending <= 1'b0;
      else if (tick && busy) pending <= 1'b1;
      // The step's grow decision is frozen at CALC; later pulses wait for the next step
      if (state == ST_CALC) begin
        step_grow  <= (grow_latch || grow) && (length < LEN_FULL);
        grow_latch <= 1'b0;
      end else if (grow && state != ST_DEAD) begin
        grow_latch <= 1'b1;
      end
      case (state)
        ST_INIT: if (accept) begin
          head_ptr <= head_ptr + 1'b1;
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == INIT_LAST) length <= LEN_W'(START_LEN);
        end
        ST_CALC: begin
          next_x   <= calc_x;
          next_y   <= calc_y;
          dir_cur  <= dir_req;
          scan_idx <= '0;
          scan_ptr <= tail_ptr + 1'b1;
        end
        ST_SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          scan_ptr <= scan_ptr + 1'b1;
          if (scan_idx == '0) {tail_x, tail_y} <= ram_rdata;
        end
        ST_ERASE: if (accept) tail_ptr <= tail_ptr + 1'b1;
        ST_COMMIT: begin
          head_x   <= next_x;
          head_y   <= next_y;
          head_ptr <= head_ptr + 1'b1;
          if (step_grow) length <= length + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine (MAX_LEN reduced to 8 so the body
// can fill up). Honours SNAKE_WRAP_EN for the edge test.
module tb_snake_engine;
  import snake_pkg::*;

  localparam int MAXL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       grow = 1'b0;
  logic       plot_ready = 1'b1;
  logic [3:0] dir_in = DIR_RIGHT;
  logic [2:0] colour_snake = COLOUR_GREEN;
  logic [2:0] colour_bg = COLOUR_BLACK;
  logic [7:0] plot_x, head_x;
  logic [6:0] plot_y, head_y;
  logic [2:0] plot_colour;
  logic       plot_valid, busy, dead;
  logic [3:0] length;

  int n_checks = 0;
  int n_pass   = 0;

  logic [14:0] body[$];
  logic [17:0] sb[$];
  logic [3:0]  m_dir, m_req;
  bit          m_dead;

  snake_engine #(.MAX_LEN(MAXL)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .dir_in       (dir_in),
    .grow         (grow),
    .colour_snake (colour_snake),
    .colour_bg    (colour_bg),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .plot_valid   (plot_valid),
    .plot_ready   (plot_ready),
    .head_x       (head_x),
    .head_y       (head_y),
    .length       (length),
    .busy         (busy),
    .dead         (dead)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Every accepted plot must be the oldest expected command
  always @(negedge clk) begin
    if (!rst && plot_valid && plot_ready) begin
      checkOutput("plot_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) checkOutput("plot_cmd", 32'({plot_x, plot_y, plot_colour}), 32'(sb.pop_front()));
    end
  end

  task automatic model_init();
    body.delete();
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      body.push_back({8'(77 + i), 7'd60});
      sb.push_back({8'(77 + i), 7'd60, COLOUR_GREEN});
    end
    m_dir  = DIR_RIGHT;
    m_req  = DIR_RIGHT;
    m_dead = 1'b0;
  endtask

  task automatic model_step(input bit g);
    logic [7:0]  hx, nx;
    logic [6:0]  hy, ny;
    logic [14:0] t;
    bit wall, hit, gro;
    if (m_dead) return;
    m_dir = m_req;
    {hx, hy} = body[$];
    nx = hx;
    ny = hy;
    wall = 1'b0;
    hit = 1'b0;
    case (m_dir)
      DIR_RIGHT: if (hx == 8'd159) begin
`ifdef SNAKE_WRAP_EN
        nx = 8'd0;
`else
        wall = 1'b1;
`endif
      end else nx = hx + 8'd1;
      DIR_LEFT: if (hx == 8'd0) begin
`ifdef SNAKE_WRAP_EN
        nx = 8'd159;
`else
        wall = 1'b1;
`endif
      end else nx = hx - 8'd1;
      DIR_DOWN: if (hy == 7'd119) begin
`ifdef SNAKE_WRAP_EN
        ny = 7'd0;
`else
        wall = 1'b1;
`endif
      end else ny = hy + 7'd1;
      default: if (hy == 7'd0) begin
`ifdef SNAKE_WRAP_EN
        ny = 7'd119;
`else
        wall = 1'b1;
`endif
      end else ny = hy - 7'd1;
    endcase
    if (wall) begin
      m_dead = 1'b1;
      return;
    end
    gro = g && (body.size() < MAXL);
    for (int i = (gro ? 0 : 1); i < body.size(); i++)
      if (body[i] == {nx, ny}) hit = 1'b1;
    if (hit) begin
      m_dead = 1'b1;
      return;
    end
    if (!gro) begin
      t = body.pop_front();
      sb.push_back({t, COLOUR_BLACK});
    end
    sb.push_back({nx, ny, COLOUR_GREEN});
    body.push_back({nx, ny});
  endtask

  task automatic set_dir(input logic [3:0] d);
    dir_in = d;
    if ($onehot(d) && d != dir_reverse(m_dir)) m_req = d;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic check_state(input string tag);
    logic [14:0] h;
    h = body[$];
    checkOutput({tag, "_head_x"}, 32'(head_x), 32'(h[14:7]));
    checkOutput({tag, "_head_y"}, 32'(head_y), 32'(h[6:0]));
    checkOutput({tag, "_length"}, 32'(length), 32'(body.size()));
    checkOutput({tag, "_dead"}, 32'(dead), 32'(m_dead));
    checkOutput({tag, "_plots_done"}, 32'(sb.size()), 0);
  endtask

  task automatic applyStimulus(input string tag, input bit g);
    model_step(g);
    @(posedge clk); #1;
    tick = 1'b1;
    grow = g;
    @(posedge clk); #1;
    tick = 1'b0;
    grow = 1'b0;
    wait_idle(tag);
    check_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    checkOutput("rst_plot_valid", 32'(plot_valid), 0);
    checkOutput("rst_busy", 32'(busy), 1);
    checkOutput("rst_length", 32'(length), 0);
    checkOutput("rst_dead", 32'(dead), 0);
    checkOutput("rst_head_x", 32'(head_x), 80);
    checkOutput("rst_head_y", 32'(head_y), 60);
    model_init();
    dir_in = DIR_RIGHT;
    @(negedge clk);
    rst = 1'b0;
    wait_idle("init");
    check_state("init");
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Plain step, then growth up to the buffer depth and one grow past it
    applyStimulus("step_right", 1'b0);
    applyStimulus("grow1", 1'b1);
    applyStimulus("grow2", 1'b1);
    applyStimulus("grow3", 1'b1);
    applyStimulus("grow4", 1'b1);
    checkOutput("len_full", 32'(length), MAXL);
    applyStimulus("grow_at_max", 1'b1);

    // Reversal request is ignored
    set_dir(DIR_LEFT);
    applyStimulus("reverse_ignored", 1'b0);

    // Stall DRAW for 5 cycles while two ticks arrive
    plot_ready = 1'b0;
    model_step(1'b0);
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    for (int n = 0; n < 200 && !plot_valid; n++) @(negedge clk);
    checkOutput("erase_valid", 32'(plot_valid), 1);
    @(posedge clk); #1;
    plot_ready = 1'b1;
    @(posedge clk); #1;
    plot_ready = 1'b0;
    model_step(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tick = (i == 0 || i == 2);
      @(negedge clk);
      checkOutput("stall_hold", 32'({plot_valid, plot_x, plot_y, plot_colour}), 32'({1'b1, sb[0]}));
    end
    @(posedge clk); #1;
    tick = 1'b0;
    plot_ready = 1'b1;
    wait_idle("stall_step");
    @(negedge clk);
    checkOutput("pending_step_busy", 32'(busy), 1);
    wait_idle("pending_step");
    check_state("pending_step");
    repeat (10) @(negedge clk);
    checkOutput("no_third_step", 32'(busy), 0);
    check_state("after_pending");

    // Turn back into the body
    set_dir(DIR_UP);
    applyStimulus("turn_up", 1'b0);
    set_dir(DIR_LEFT);
    applyStimulus("turn_left", 1'b0);
    set_dir(DIR_DOWN);
    applyStimulus("self_hit", 1'b0);
    checkOutput("self_hit_dead", 32'(dead), 1);
    applyStimulus("dead_ignores", 1'b1);

    // Reset aborts a stalled plot asynchronously
    plot_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("init_stall_valid", 32'(plot_valid), 1);
    checkOutput("init_stall_x", 32'(plot_x), 77);
    rst = 1'b1;
    #1;
    checkOutput("async_valid_drop", 32'(plot_valid), 0);
    plot_ready = 1'b1;
    do_reset();

    // Walk to the right edge, with malformed directions along the way
    for (int i = 0; i < 79; i++) begin
      if (i == 10) set_dir(4'b0000);
      if (i == 20) set_dir(4'b0101);
      applyStimulus("walk", 1'b0);
    end
    checkOutput("edge_head_x", 32'(head_x), 159);
    applyStimulus("edge_step", 1'b0);
`ifdef SNAKE_WRAP_EN
    checkOutput("edge_wrap_x", 32'(head_x), 0);
`else
    checkOutput("edge_wall_dead", 32'(dead), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
